// File: rtl/nios_sampler_cpu_cpu_debug_ocimem_ctrl.sv
// Debug-memory command executor: turns sysclk-stage strobes + jdo into Avalon-style reads/writes.
// Latency 2 cycles strobe-to-ready with no wait states; waitrequest stalls, aborting after TIMEOUT cycles.
module nios_sampler_cpu_cpu_debug_ocimem_ctrl #(
  parameter int AW      = 8,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [37:0]   jdo,
  input  logic          take_action_ocimem_a,
  input  logic          take_action_ocimem_b,
  input  logic          take_no_action_ocimem_a,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic          mem_read,
  output logic          mem_write,
  input  logic [31:0]   mem_rdata,
  input  logic          mem_waitrequest,
  output logic [31:0]   MonDReg,
  output logic          monitor_ready,
  output logic          monitor_error,
  output logic [AW-1:0] busy_cnt
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_e;

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     dreg_q, dreg_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            err_q, err_d;
  logic [CW-1:0]   tmo_q, tmo_d;
  logic            err_set, err_clr;
  logic            clr_only;

  logic unused_jdo;
  assign unused_jdo = ^{jdo[37], jdo[34:32]};

  // An ocimem_a that only clears the error is legal even while an access is in flight.
  assign clr_only = take_action_ocimem_a && jdo[35] && !jdo[36];

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    dreg_d  = dreg_q;
    wdata_d = wdata_q;
    tmo_d   = tmo_q;
    err_set = 1'b0;
    err_clr = 1'b0;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (take_action_ocimem_a) begin
          addr_d  = jdo[AW+1:2];
          err_clr = jdo[35];
          err_set = take_action_ocimem_b || take_no_action_ocimem_a;
          if (jdo[36]) state_d = READ;
        end else if (take_action_ocimem_b) begin
          state_d = WRITE;
          dreg_d  = jdo[31:0];
          wdata_d = jdo[31:0];
          err_set = take_no_action_ocimem_a;
        end else if (take_no_action_ocimem_a) begin
          state_d = READ;
        end
      end
      READ, WRITE: begin
        err_clr = clr_only;
        err_set = (take_action_ocimem_a && !clr_only) || take_action_ocimem_b ||
                  take_no_action_ocimem_a;
        if (!mem_waitrequest) begin
          if (state_q == READ) dreg_d = mem_rdata;
          addr_d  = addr_q + 1'b1;
          state_d = IDLE;
          tmo_d   = '0;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          state_d = IDLE;
          err_set = 1'b1;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A set in the same cycle as a clear takes precedence.
    err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      dreg_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      dreg_q  <= dreg_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_read      = (state_q == READ);
  assign mem_write     = (state_q == WRITE);
  assign MonDReg       = dreg_q;
  assign monitor_ready = (state_q == IDLE);
  assign monitor_error = err_q;
  assign busy_cnt      = addr_q;

endmodule

// File: tb/tb_nios_sampler_cpu_cpu_debug_ocimem_ctrl.sv
// Bench: directed vector table, hand-written corner sequences, then random commands vs a transaction model.
module tb_nios_sampler_cpu_cpu_debug_ocimem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        st_a = 1'b0, st_b = 1'b0, st_n = 1'b0;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_rdata;
  logic        mem_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  logic [7:0]  busy_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  nios_sampler_cpu_cpu_debug_ocimem_ctrl #(.AW(8), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(st_a), .take_action_ocimem_b(st_b), .take_no_action_ocimem_a(st_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_waitrequest(mem_waitrequest),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory responder: stalls each access for wait_cfg cycles, logs accepted accesses.
  logic [31:0] mem [256];
  int          wait_cfg = 0;
  int          rd_total = 0, wr_total = 0, acc_total = 0;
  logic [7:0]  last_acc_addr;
  logic [31:0] last_acc_dat;

  initial begin
    int   stall;
    bit   held;
    logic [7:0]  h_addr;
    logic [31:0] h_dat;
    stall = 0;
    held  = 0;
    h_addr = '0;
    h_dat  = '0;
    mem_waitrequest = 1'b0;
    mem_rdata = '0;
    last_acc_addr = '0;
    last_acc_dat  = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[8'hFF] = 32'hCAFEF00D;
    mem[8'h31] = 32'h0BADF00D;
    forever begin
      @(negedge clk);
      if (!reset && (mem_read || mem_write)) begin
        chk("req_exclusive", 64'(mem_read && mem_write), 64'd0);
        if (!held) begin
          held = 1;
          h_addr = mem_addr;
          h_dat  = mem_wdata;
        end else begin
          chk("addr_stable", 64'(mem_addr), 64'(h_addr));
          if (mem_write) chk("wdata_stable", 64'(mem_wdata), 64'(h_dat));
        end
        if (mem_read) rd_total++; else wr_total++;
        if (stall < wait_cfg) begin
          mem_waitrequest = 1'b1;
          stall++;
        end else begin
          mem_waitrequest = 1'b0;
          acc_total++;
          last_acc_addr = mem_addr;
          if (mem_write) begin
            mem[mem_addr] = mem_wdata;
            last_acc_dat  = mem_wdata;
          end else begin
            mem_rdata    = mem[mem_addr];
            last_acc_dat = mem[mem_addr];
          end
        end
      end else begin
        held = 0;
        stall = 0;
        mem_waitrequest = 1'b0;
      end
    end
  end

  task automatic issue(input bit a, input bit b, input bit n, input logic [37:0] d);
    @(negedge clk);
    jdo  = d;
    st_a = a;
    st_b = b;
    st_n = n;
    @(posedge clk);
    #1;
    st_a = 1'b0;
    st_b = 1'b0;
    st_n = 1'b0;
  endtask

  // Cycles from the strobe cycle until monitor_ready is seen high (1 = never went busy).
  task automatic wait_ready(output int lat);
    lat = 1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (monitor_ready) break;
      lat++;
    end
  endtask

  typedef struct {
    bit          a, b, n;
    logic [37:0] jdo;
    int          waits;
    logic [7:0]  e_addr;
    logic [31:0] e_dreg;
    bit          e_err;
    int          e_lat;
    int          e_rd;
    int          e_wr;
    bit          e_acc;
    logic [7:0]  e_acc_addr;
  } vec_t;

  vec_t vt[10];

  initial begin
    int lat, rd0, wr0, acc0;
    int m_addr, acc_kind, waits, exp_lat, exp_nacc, sel;
    logic [31:0] m_dreg, data, exp_acc_dat, mem_ref [256];
    logic [37:0] rj;
    bit  m_err, a, b, n;
    logic [7:0] exp_acc_addr;

    vt[0] = '{1,0,0, 38'h00_0000_0040,    0, 8'h10, 32'h0,        0,  1,  0, 0, 0, 8'h00};
    vt[1] = '{0,1,0, 38'h00_DEAD_BEEF,    0, 8'h11, 32'hDEADBEEF, 0,  2,  0, 1, 1, 8'h10};
    vt[2] = '{1,0,0, 38'h10_0000_0040,    3, 8'h11, 32'hDEADBEEF, 0,  5,  4, 0, 1, 8'h10};
    vt[3] = '{1,0,0, 38'h00_0000_03FC,    0, 8'hFF, 32'hDEADBEEF, 0,  1,  0, 0, 0, 8'h00};
    vt[4] = '{0,0,1, 38'h00_0000_0000,    0, 8'h00, 32'hCAFEF00D, 0,  2,  1, 0, 1, 8'hFF};
    vt[5] = '{0,0,1, 38'h00_0000_0000, 1000, 8'h00, 32'hCAFEF00D, 1, 65, 64, 0, 0, 8'h00};
    vt[6] = '{1,0,0, 38'h08_0000_0000,    0, 8'h00, 32'hCAFEF00D, 0,  1,  0, 0, 0, 8'h00};
    vt[7] = '{0,1,1, 38'h00_1234_5678,    0, 8'h01, 32'h12345678, 1,  2,  0, 1, 1, 8'h00};
    vt[8] = '{1,1,0, 38'h08_0000_0080,    0, 8'h20, 32'h12345678, 1,  1,  0, 0, 0, 8'h00};
    vt[9] = '{1,0,0, 38'h08_0000_00C0,    0, 8'h30, 32'h12345678, 0,  1,  0, 0, 0, 8'h00};

    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(monitor_ready), 64'd1);
    chk("rst_error", 64'(monitor_error), 64'd0);
    chk("rst_dreg",  64'(MonDReg),       64'd0);
    chk("rst_areg",  64'(busy_cnt),      64'd0);
    chk("rst_req",   64'({mem_read, mem_write}), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      wait_cfg = vt[i].waits;
      rd0 = rd_total; wr0 = wr_total; acc0 = acc_total;
      issue(vt[i].a, vt[i].b, vt[i].n, vt[i].jdo);
      wait_ready(lat);
      chk($sformatf("v%0d_lat", i),  64'(lat),            64'(vt[i].e_lat));
      chk($sformatf("v%0d_areg", i), 64'(busy_cnt),       64'(vt[i].e_addr));
      chk($sformatf("v%0d_dreg", i), 64'(MonDReg),        64'(vt[i].e_dreg));
      chk($sformatf("v%0d_err", i),  64'(monitor_error),  64'(vt[i].e_err));
      chk($sformatf("v%0d_rdcyc", i), 64'(rd_total - rd0), 64'(vt[i].e_rd));
      chk($sformatf("v%0d_wrcyc", i), 64'(wr_total - wr0), 64'(vt[i].e_wr));
      chk($sformatf("v%0d_nacc", i), 64'(acc_total - acc0), 64'(vt[i].e_acc));
      if (vt[i].e_acc)
        chk($sformatf("v%0d_accaddr", i), 64'(last_acc_addr), 64'(vt[i].e_acc_addr));
    end
    chk("mem0_written", 64'(mem[0]), 64'h12345678);

    // Overrun: no_action strobe while a write is stalled.
    wait_cfg = 10;
    rd0 = rd_total; wr0 = wr_total;
    issue(0, 1, 0, 38'h00_55AA_55AA);
    repeat (2) @(negedge clk);
    issue(0, 0, 1, 38'h0);
    wait_ready(lat);
    chk("ovr_err",   64'(monitor_error), 64'd1);
    chk("ovr_areg",  64'(busy_cnt),      64'h31);
    chk("ovr_dreg",  64'(MonDReg),       64'h55AA55AA);
    chk("ovr_wrcyc", 64'(wr_total - wr0), 64'd11);
    chk("ovr_rdcyc", 64'(rd_total - rd0), 64'd0);
    chk("ovr_mem",   64'(mem[8'h30]),    64'h55AA55AA);

    // Clear-only ocimem_a while busy: error clears, address untouched.
    wait_cfg = 6;
    rd0 = rd_total;
    issue(0, 0, 1, 38'h0);
    issue(1, 0, 0, 38'h08_0000_01DC);
    wait_ready(lat);
    chk("clrbusy_err",   64'(monitor_error), 64'd0);
    chk("clrbusy_areg",  64'(busy_cnt),      64'h32);
    chk("clrbusy_dreg",  64'(MonDReg),       64'h0BADF00D);
    chk("clrbusy_rdcyc", 64'(rd_total - rd0), 64'd7);

    // Reset in the middle of a stalled read.
    wait_cfg = 1000;
    issue(0, 0, 1, 38'h0);
    repeat (5) @(negedge clk);
    chk("pre_rst_read", 64'(mem_read), 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_read",  64'(mem_read),      64'd0);
    chk("midrst_ready", 64'(monitor_ready), 64'd1);
    chk("midrst_areg",  64'(busy_cnt),      64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Random commands against a transaction-level model.
    for (int i = 0; i < 256; i++) mem_ref[i] = mem[i];
    m_addr = 0;
    m_dreg = '0;
    m_err  = 1'b0;
    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(1, 7);
      a = sel[0]; b = sel[1]; n = sel[2];
      rj = {6'($urandom_range(0, 63)), 32'($urandom)};
      waits = ($urandom_range(0, 19) < 2) ? 70 : $urandom_range(0, 4);
      acc_kind = 0;
      data = rj[31:0];
      if (a) begin
        m_addr = int'(rj[9:2]);
        if (rj[35]) m_err = 1'b0;
        if (b || n) m_err = 1'b1;
        if (rj[36]) acc_kind = 1;
      end else if (b) begin
        acc_kind = 2;
        m_dreg = data;
        if (n) m_err = 1'b1;
      end else begin
        acc_kind = 1;
      end
      exp_lat = 1;
      exp_nacc = 0;
      exp_acc_addr = '0;
      exp_acc_dat = '0;
      if (acc_kind != 0) begin
        if (waits >= 64) begin
          m_err = 1'b1;
          exp_lat = 65;
        end else begin
          exp_lat = waits + 2;
          exp_nacc = 1;
          exp_acc_addr = 8'(m_addr);
          if (acc_kind == 1) m_dreg = mem_ref[m_addr];
          else mem_ref[m_addr] = data;
          exp_acc_dat = (acc_kind == 1) ? mem_ref[m_addr] : data;
          m_addr = (m_addr + 1) % 256;
        end
      end
      wait_cfg = waits;
      acc0 = acc_total;
      issue(a, b, n, rj);
      wait_ready(lat);
      chk($sformatf("r%0d_lat", t),  64'(lat),           64'(exp_lat));
      chk($sformatf("r%0d_areg", t), 64'(busy_cnt),      64'(m_addr));
      chk($sformatf("r%0d_dreg", t), 64'(MonDReg),       64'(m_dreg));
      chk($sformatf("r%0d_err", t),  64'(monitor_error), 64'(m_err));
      chk($sformatf("r%0d_nacc", t), 64'(acc_total - acc0), 64'(exp_nacc));
      if (exp_nacc == 1) begin
        chk($sformatf("r%0d_accaddr", t), 64'(last_acc_addr), 64'(exp_acc_addr));
        chk($sformatf("r%0d_accdat", t),  64'(last_acc_dat),  64'(exp_acc_dat));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
